// File: rtl/dsp_result_uart.sv
`timescale 1ns/1ps
// Captures a 12-bit solver result, converts it to BCD with a sequential double-dabble, then sends "dddd\r\n" as 8N1 UART.
// Start bit leaves 13 cycles after capture; strobes arriving while busy are dropped and flagged with a one-cycle overrun pulse.
module dsp_result_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] solved_dsp,
    input  logic        solved_valid,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

    localparam logic [15:0] BAUD_TOP = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nx;
    logic [11:0] bin, bin_nx;
    logic [15:0] bcd, bcd_nx;
    logic [3:0]  shift_cnt, shift_cnt_nx;
    logic [2:0]  byte_idx, byte_idx_nx;
    logic [3:0]  bit_idx, bit_idx_nx;
    logic [15:0] baud_cnt, baud_cnt_nx;
    logic        tx_nx, busy_nx, done_nx, overrun_nx;
    logic [7:0]  cur_byte;
    logic [15:0] frame;
    logic [27:0] dabble;

    // Nibbles never exceed 9 before the adjust, so a 4-bit add cannot carry.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = 8'h30 + {4'h0, bcd[15:12]};
            3'd1:    cur_byte = 8'h30 + {4'h0, bcd[11:8]};
            3'd2:    cur_byte = 8'h30 + {4'h0, bcd[7:4]};
            3'd3:    cur_byte = 8'h30 + {4'h0, bcd[3:0]};
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Bit 0 is the start bit; indices 9 and above read as stop/idle level.
    assign frame  = {7'h7F, cur_byte, 1'b0};
    assign dabble = {bcd_adjust(bcd), bin} << 1;

    always_comb begin
        state_nx     = state;
        bin_nx       = bin;
        bcd_nx       = bcd;
        shift_cnt_nx = shift_cnt;
        byte_idx_nx  = byte_idx;
        bit_idx_nx   = bit_idx;
        baud_cnt_nx  = baud_cnt;
        tx_nx        = 1'b1;
        busy_nx      = busy;
        done_nx      = 1'b0;
        overrun_nx   = solved_valid && (state != IDLE);

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (solved_valid) begin
                    bin_nx       = solved_dsp;
                    bcd_nx       = '0;
                    shift_cnt_nx = '0;
                    busy_nx      = 1'b1;
                    state_nx     = CONVERT;
                end
            end
            CONVERT: begin
                bcd_nx       = dabble[27:12];
                bin_nx       = dabble[11:0];
                shift_cnt_nx = shift_cnt + 4'd1;
                if (shift_cnt == 4'd11) begin
                    byte_idx_nx = '0;
                    bit_idx_nx  = '0;
                    baud_cnt_nx = BAUD_TOP;
                    state_nx    = SEND;
                end
            end
            SEND: begin
                tx_nx = frame[bit_idx];
                // bit_idx 10 is a one-cycle tail after the final stop bit.
                if (bit_idx == 4'd10) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (baud_cnt == 16'd0) begin
                    baud_cnt_nx = BAUD_TOP;
                    if (bit_idx == 4'd9) begin
                        if (byte_idx == 3'd5) begin
                            bit_idx_nx = 4'd10;
                        end else begin
                            byte_idx_nx = byte_idx + 3'd1;
                            bit_idx_nx  = '0;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            bin       <= bin_nx;
            bcd       <= bcd_nx;
            shift_cnt <= shift_cnt_nx;
            byte_idx  <= byte_idx_nx;
            bit_idx   <= bit_idx_nx;
            baud_cnt  <= baud_cnt_nx;
            tx        <= tx_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            overrun   <= overrun_nx;
        end
    end
endmodule
